// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write bus shared by imem_loader and its environment.
// The loader sits on the slave modport; the byte source / RAM side uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to instruction-RAM loader; holds the core in reset until done.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the data words.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef IMEM_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
`endif
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  logic [2:0]  state;
  logic [15:0] len_n;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum;
`endif

  logic        xfer;
  logic [15:0] len_in;
  logic        last_word;

  assign xfer      = bus.rx_valid && bus.rx_ready;
  assign len_in    = {bus.rx_data, len_n[7:0]};
  assign last_word = (wcnt == len_n - 16'd1);

  // NOTE: every register here is state, so all updates use <= to avoid ordering races.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state          <= S_IDLE;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_rst       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      word_count     <= '0;
      len_n          <= '0;
      wcnt           <= '0;
      bcnt           <= '0;
      shreg          <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum           <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      if (start && !busy) begin
        state        <= S_LEN0;
        bus.rx_ready <= 1'b1;
        core_rst     <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        word_count   <= '0;
        wcnt         <= '0;
        bcnt         <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum         <= '0;
`endif
      end else begin
        case (state)
          S_LEN0: if (xfer) begin
            len_n[7:0] <= bus.rx_data;
            state      <= S_LEN1;
          end
          S_LEN1: if (xfer) begin
            len_n[15:8] <= bus.rx_data;
            // Oversized images are rejected before any RAM word is touched.
            if (len_in == 16'd0 || {1'b0, len_in} > CAP) begin
              state        <= S_ERR;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              err          <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: if (xfer) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {bus.rx_data, shreg[23:8]};
`ifdef IMEM_LOADER_CSUM_EN
            csum  <= csum ^ bus.rx_data;
`endif
            if (bcnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= wcnt[ADDR_W-1:0];
              bus.imem_wdata <= {bus.rx_data, shreg};
              wcnt           <= wcnt + 16'd1;
              word_count     <= wcnt + 16'd1;
              if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                state        <= S_CSUM;
`else
                state        <= S_DONE;
                bus.rx_ready <= 1'b0;
`endif
              end
            end
          end
`ifdef IMEM_LOADER_CSUM_EN
          S_CSUM: if (xfer) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.rx_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
`endif
          // Without a checksum, completion lands one cycle after the final write.
          S_DONE: if (busy) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: loads are generated as byte lists, expected RAM writes
// are queued from the image contents, and a monitor pops and compares on every imem_we.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        core_rst, busy, done, err;
  logic [15:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .bus        (bus.slave),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] ram [CAP];
  logic [7:0]  preset[$];
  int          tests = 0;
  int          fails = 0;
  int          writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the RAM model and scoreboard consume every write strobe.
  always @(negedge clk) begin
    if (!rstn && bus.imem_we === 1'b1) begin
      writes_seen++;
      ram[bus.imem_addr] = bus.imem_wdata;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
        check("write_data", bus.imem_wdata, mon_e.data);
      end
    end
  end

  // Returns at the falling edge following the accepting rising edge, rx_valid still high.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    while (bus.rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got rx_ready=0, expected 1 within 100 cycles");
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input int gap_max, input bit mid_start, input bit bad_csum);
    logic [7:0] data[$];
    logic [7:0] x;
    wr_t        ew;
    bit         len_ok;
    int         base;
    len_ok = (n >= 1 && n <= CAP);
    x = 8'h00;
    if (len_ok) begin
      for (int i = 0; i < 4 * n; i++) begin
        data.push_back(i < preset.size() ? preset[i] : 8'($urandom));
        x = x ^ data[i];
      end
      for (int w = 0; w < n; w++) begin
        ew.addr = ADDR_W'(w % CAP);
        ew.data = 32'(data[4*w]) + 32'(data[4*w+1]) * 256 +
                  32'(data[4*w+2]) * 65536 + 32'(data[4*w+3]) * 16777216;
        exp_q.push_back(ew);
      end
    end
    base = writes_seen;
    pulse_start();
    check("start_busy", 32'(busy), 1);
    check("start_core_rst", 32'(core_rst), 1);
    check("start_rx_ready", 32'(bus.rx_ready), 1);
    check("start_flags", {30'd0, done, err}, 0);
    check("start_word_count", 32'(word_count), 0);
    send_byte(8'(n), 0);
    send_byte(8'(n >> 8), 0);
    if (!len_ok) begin
      bus.rx_valid = 1'b0;
      check("len_err", 32'(err), 1);
      check("len_err_busy", 32'(busy), 0);
      check("len_err_core_rst", 32'(core_rst), 1);
      check("len_err_rx_ready", 32'(bus.rx_ready), 0);
      repeat (3) @(negedge clk);
      check("len_err_writes", 32'(writes_seen - base), 0);
      return;
    end
    for (int i = 0; i < 4 * n; i++) begin
      if (mid_start && i == 5) begin
        bus.rx_valid = 1'b0;
        pulse_start();
      end
      send_byte(data[i], gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, 0);
    bus.rx_valid = 1'b0;
    check("csum_busy", 32'(busy), 0);
    check("csum_done", 32'(done), bad_csum ? 0 : 1);
    check("csum_err", 32'(err), bad_csum ? 1 : 0);
    check("csum_core_rst", 32'(core_rst), bad_csum ? 1 : 0);
`else
    bus.rx_valid = 1'b0;
    check("last_write_busy", 32'(busy), 1);
    check("last_write_done", 32'(done), 0);
    @(negedge clk);
    check("done", 32'(done), 1);
    check("done_core_rst", 32'(core_rst), 0);
    check("done_busy", 32'(busy), 0);
    check("done_rx_ready", 32'(bus.rx_ready), 0);
`endif
    check("word_count", 32'(word_count), 32'(n));
    repeat (2) @(negedge clk);
    check("writes_total", 32'(writes_seen - base), 32'(n));
    check("scoreboard_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    check({tag, "_core_rst"}, 32'(core_rst), 1);
    check({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 0);
    check({tag, "_word_count"}, 32'(word_count), 0);
  endtask

  initial begin
    int base;
    wr_t ew;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset held three cycles with a coincident start: reset must win.
    rstn  = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rstn  = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Bytes offered while idle are not consumed and cause no writes.
    base = writes_seen;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_rx_ready", 32'(bus.rx_ready), 0);
    bus.rx_valid = 1'b0;
    check("idle_writes", 32'(writes_seen - base), 0);

    // Basic two-word load.
    preset = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
    run_load(2, 0, 1'b0, 1'b0);
    check("basic_ram0", ram[0], 32'h0000_0013);
    check("basic_ram1", ram[1], 32'h0010_0293);
    preset.delete();

    // Length errors.
    run_load(0, 0, 1'b0, 1'b0);
    run_load(CAP + 1, 0, 1'b0, 1'b0);

    // Full capacity, then a short load that must restart at address 0.
    run_load(CAP, 0, 1'b0, 1'b0);
    run_load(3, 0, 1'b0, 1'b0);

    // Random images with random gaps and a stray start mid-data.
    for (int k = 0; k < 6; k++)
      run_load(int'($urandom_range(20, 2)), 5, 1'b1, 1'b0);

    // Reset after one and a half words.
    preset = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ew.addr = '0;
    ew.data = 32'h4433_2211;
    exp_q.push_back(ew);
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(preset[i], 0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    base = writes_seen;
    repeat (2) @(negedge clk);
    check_reset_values("midreset");
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_writes", 32'(writes_seen - base), 0);
    check("midreset_first_word", ram[0], 32'h4433_2211);
    check("midreset_drained", 32'(exp_q.size()), 0);
    preset.delete();
    run_load(5, 2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    preset = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(1, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b0, 1'b1);
    check("csum_bad_ram0", ram[0], 32'h0000_0013);
    preset.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no completion, expected finish within 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
